// File: rtl/divider_nr.sv
// divider_nr: multi-cycle non-restoring signed/unsigned integer divider with start/done handshake
module divider_nr #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bgn,
  input  logic             sgn,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             fin,
  output logic             div_zero,
  output logic             ovf
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  typedef enum logic [2:0] {IDLE, PREP, ITER, CORR, DONE} state_t;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             sgn_r, neg_q, neg_r;
  logic [WIDTH-1:0] a, b, dm, q;
  logic [WIDTH:0]   p, p_sh, p_nx, p_fix;
  always_comb begin
    p_sh  = {p[WIDTH-1:0], q[WIDTH-1]};
    p_nx  = p[WIDTH] ? p_sh + {1'b0, dm} : p_sh - {1'b0, dm};
    p_fix = p[WIDTH] ? p + {1'b0, dm} : p;
  end
  // q holds the dividend magnitude and shifts quotient bits in from the right
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      busy      <= 1'b0;
      fin       <= 1'b0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bgn) begin
          sgn_r    <= sgn;
          a        <= dividend;
          b        <= divisor;
          busy     <= 1'b1;
          div_zero <= 1'b0;
          ovf      <= 1'b0;
          state    <= PREP;
        end
        PREP: begin
          q     <= (sgn_r & a[WIDTH-1]) ? -a : a;
          dm    <= (sgn_r & b[WIDTH-1]) ? -b : b;
          neg_q <= sgn_r & (a[WIDTH-1] ^ b[WIDTH-1]);
          neg_r <= sgn_r & a[WIDTH-1];
          p     <= '0;
          cnt   <= '0;
          state <= (b == '0) ? CORR : ITER;
        end
        ITER: begin
          p     <= p_nx;
          q     <= {q[WIDTH-2:0], ~p_nx[WIDTH]};
          cnt   <= cnt + CNT_W'(1);
          state <= (cnt == CNT_W'(WIDTH - 1)) ? CORR : ITER;
        end
        CORR: begin
          fin       <= 1'b1;
          state     <= DONE;
          div_zero  <= (b == '0);
          ovf       <= sgn_r & (a == MIN_NEG) & (b == '1);
          quotient  <= (b == '0) ? '1 : (neg_q ? -q : q);
          remainder <= (b == '0) ? a : (neg_r ? -p_fix[WIDTH-1:0] : p_fix[WIDTH-1:0]);
        end
        DONE: begin
          fin   <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_nr.sv
// tb_divider_nr: directed and random division checks against an arithmetic reference model
module tb_divider_nr;
  localparam int W = 16;
  logic         clk = 1'b0;
  logic         rst, bgn, sgn;
  logic [W-1:0] dividend, divisor, quotient, remainder;
  logic         busy, fin, div_zero, ovf;
  int           n_cmp = 0;
  int           n_bad = 0;

  divider_nr #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .bgn(bgn), .sgn(sgn), .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder), .busy(busy), .fin(fin),
    .div_zero(div_zero), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // truncating division from plain integer arithmetic
  task automatic model(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r,
                       output logic dz, output logic ov);
    longint sa, sb;
    dz = (b == 0);
    ov = 1'b0;
    if (dz) begin
      q = '1;
      r = a;
    end else if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = W'(sa / sb);
      r  = W'(sa % sb);
      ov = (sa / sb) > longint'((1 << (W - 1)) - 1);
    end else begin
      q = a / b;
      r = a % b;
    end
  endtask

  // called at a negedge; returns at the negedge of the first idle cycle after fin
  task automatic run_op(input logic sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit pulse);
    logic [W-1:0] eq, er;
    logic         edz, eov;
    int           k, bc, lat;
    string        t;
    model(sg, a, b, eq, er, edz, eov);
    lat = edz ? 3 : W + 3;
    t = $sformatf("%s %h/%h", sg ? "s" : "u", a, b);
    sgn = sg; dividend = a; divisor = b; bgn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bgn = 1'b0; sgn = 1'($urandom); dividend = W'($urandom); divisor = W'($urandom);
    k = 1;
    bc = int'(busy);
    while (!fin && k < 64) begin
      @(negedge clk);
      k++;
      bc += int'(busy);
      bgn = pulse && k == 5;
    end
    check({t, " latency"}, 32'(k), 32'(lat));
    check({t, " busy_cycles"}, 32'(bc), 32'(lat));
    check({t, " quotient"}, 32'(quotient), 32'(eq));
    check({t, " remainder"}, 32'(remainder), 32'(er));
    check({t, " div_zero"}, 32'(div_zero), 32'(edz));
    check({t, " ovf"}, 32'(ovf), 32'(eov));
    bgn = pulse;
    @(negedge clk);
    bgn = 1'b0;
    check({t, " fin_width"}, 32'(fin), 32'd0);
    check({t, " busy_end"}, 32'(busy), 32'd0);
    check({t, " q_hold"}, 32'(quotient), 32'(eq));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         seen;
    logic [W-1:0] ra, rb;
    logic         rs;
    rst = 1'b0; bgn = 1'b0; sgn = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(negedge clk);
    check("reset outputs", 32'({quotient, remainder, busy, fin, div_zero, ovf}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    run_op(1'b0, 16'd100, 16'd7, 1'b0);
    run_op(1'b1, 16'hFF9C, 16'd7, 1'b0);
    run_op(1'b1, 16'd100, 16'hFFF9, 1'b0);
    run_op(1'b0, 16'h04D2, 16'h0000, 1'b0);
    run_op(1'b1, 16'h04D2, 16'h0000, 1'b0);
    run_op(1'b1, 16'h8000, 16'hFFFF, 1'b0);
    run_op(1'b0, 16'h8000, 16'hFFFF, 1'b0);
    run_op(1'b0, 16'd100, 16'd7, 1'b1);
    run_op(1'b1, 16'hF123, 16'h0045, 1'b0);
    // abandon an operation with reset mid-flight
    sgn = 1'b0; dividend = 16'd1000; divisor = 16'd3; bgn = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bgn = 1'b0;
    repeat (7) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check("midop reset outputs", 32'({quotient, remainder, busy, fin, div_zero, ovf}), 32'd0);
    seen = 1'b0;
    repeat (W + 4) begin
      @(negedge clk);
      seen |= fin | busy;
    end
    check("no fin after reset", 32'(seen), 32'd0);
    run_op(1'b0, 16'hFFFF, 16'h0001, 1'b0);
    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = (i % 10 == 3) ? 16'h8000 : W'($urandom);
      rb = (i % 8 == 0) ? 16'h0000 : (i % 3 == 0) ? W'($urandom_range(1, 15)) :
           (i % 10 == 3) ? 16'hFFFF : W'($urandom);
      run_op(rs, ra, rb, 1'b0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
